// File: rtl/cond_eval_pipe.sv
// cond_eval_pipe: pipelined condition evaluator feeding a 2-entry result buffer.
// The condition code is evaluated against the operand as it arrives. The 1-bit
// result is queued behind a valid/ready handshake. in_ready depends only on
// registered occupancy, so branch-unit backpressure never reaches the ALU
// combinationally.
// Optional: define COND_STATS_EN to build saturating pop/taken counters.
module cond_eval_pipe #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           Condition,
  input  logic [WIDTH-1:0]     Input,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 Result,
  input  logic                 stats_clr,
  output logic [CNT_WIDTH-1:0] eval_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  logic       neg, zero, eval_res;
  logic [1:0] cnt;
  logic       head, tail;
  logic       push, pop;

  // Evaluate the condition code; unsigned mode masks the sign flag.
  always_comb begin
    neg  = Input[WIDTH-1] & ~Condition[3];
    zero = (Input == '0);
    case (Condition[2:0])
      3'd0:    eval_res = 1'b0;
      3'd1:    eval_res = zero;
      3'd2:    eval_res = neg;
      3'd3:    eval_res = neg | zero;
      3'd4:    eval_res = 1'b1;
      3'd5:    eval_res = ~zero;
      3'd6:    eval_res = ~neg;
      default: eval_res = ~neg & ~zero;
    endcase
  end

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign Result    = out_valid & head;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Two-entry FIFO: head is presented, tail waits behind it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= 2'd0;
      head <= 1'b0;
      tail <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= eval_res;
          else             tail <= eval_res;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        // Both at once only happens with one entry: the new result becomes head.
        2'b11:   head <= eval_res;
        default: ;
      endcase
    end
  end

`ifdef COND_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eval_count  <= '0;
      taken_count <= '0;
    end else if (stats_clr) begin
      eval_count  <= '0;
      taken_count <= '0;
    end else if (pop) begin
      if (eval_count != CNT_MAX) eval_count <= eval_count + 1'b1;
      if (Result && taken_count != CNT_MAX) taken_count <= taken_count + 1'b1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^Condition[7:4];
`else
  assign eval_count  = '0;
  assign taken_count = '0;

  logic unused_bits;
  assign unused_bits = ^{Condition[7:4], stats_clr};
`endif

endmodule

// File: tb/tb_cond_eval_pipe.sv
// Scoreboard bench for cond_eval_pipe: the driver queues the expected result
// of every accepted request; a negedge monitor compares handshake, Result and
// counters against that queue and a counter model.
module tb_cond_eval_pipe;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef COND_STATS_EN
  localparam int EXP_SAT = CMAX;
`else
  localparam int EXP_SAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, Result, stats_clr;
  logic [7:0]    Condition;
  logic [W-1:0]  Input;
  logic [CW-1:0] eval_count, taken_count;

  int  vectors = 0, miscompares = 0;
  bit  q[$];
  int  m_eval = 0, m_taken = 0;
  bit  rand_rdy = 0;

  cond_eval_pipe #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Condition(Condition), .Input(Input), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .stats_clr(stats_clr),
    .eval_count(eval_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: interpret the operand as a number and test its relation to 0.
  function automatic bit ref_eval(input logic [7:0] c, input logic [W-1:0] x);
    longint v;
    v = c[3] ? longint'({1'b0, x}) : longint'($signed(x));
    case (c[2:0])
      3'd0: return 1'b0;
      3'd1: return v == 0;
      3'd2: return v < 0;
      3'd3: return v <= 0;
      3'd4: return 1'b1;
      3'd5: return v != 0;
      3'd6: return v >= 0;
      default: return v > 0;
    endcase
  endfunction

  // Monitor: compare outputs against the scoreboard, then retire any pop.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      m_eval  = 0;
      m_taken = 0;
    end else begin
      check("in_ready", in_ready, q.size() < 2);
      check("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) check("result", Result, q[0]);
      else               check("result_idle", Result, 0);
      check("eval_count", eval_count, m_eval);
      check("taken_count", taken_count, m_taken);
`ifdef COND_STATS_EN
      if (stats_clr) begin
        m_eval  = 0;
        m_taken = 0;
      end else if (out_ready && q.size() != 0) begin
        if (m_eval < CMAX) m_eval++;
        if (q[0] && m_taken < CMAX) m_taken++;
      end
`endif
      if (out_ready && q.size() != 0) void'(q.pop_front());
    end
  end

  task automatic drive_rdy();
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one request and hold it until accepted; queue its expected result.
  task automatic send(input logic [7:0] c, input logic [W-1:0] x);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1; Condition = c; Input = x;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
      if (acc) q.push_back(ref_eval(c, x));
      #1;
      drive_rdy();
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: request cond=%0h not accepted within %0d cycles", c, n);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      drive_rdy();
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stats_clr = 1'b0;
    Condition = '0; Input = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", Result, 0);
    check("rst_eval", eval_count, 0);
    check("rst_taken", taken_count, 0);
    rst = 1'b1;

    // Zero test, then non-zero.
    out_ready = 1'b1;
    send(8'h01, 8'h00);
    send(8'h01, 8'h05);
    idle(3);

    // Signed vs unsigned on 0x80.
    send(8'h02, 8'h80);
    send(8'h0A, 8'h80);
    send(8'h07, 8'h80);
    send(8'h0F, 8'h80);
    idle(3);

    // Backpressure: two accepted, third held until the consumer resumes.
    out_ready = 1'b0;
    send(8'h04, 8'h33);
    send(8'h00, 8'h33);
    in_valid = 1'b1; Condition = 8'h04; Input = 8'h33;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h04, 8'h33);
    idle(4);

    // Steady stream sweeping all codes.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(8'(i % 8), W'($urandom));
    idle(3);

    // Asynchronous reset with a full buffer.
    out_ready = 1'b0;
    send(8'h04, 8'h01);
    send(8'h05, 8'h01);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_result", Result, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    idle(3);

    // Counter saturation, then a clear coincident with a pop.
    for (int i = 0; i < 20; i++) send(8'h04, W'($urandom));
    idle(3);
    check("eval_sat", eval_count, EXP_SAT);
    check("taken_sat", taken_count, EXP_SAT);
    out_ready = 1'b0;
    send(8'h04, 8'h00);
    idle(1);
    stats_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    check("clr_eval", eval_count, 0);
    check("clr_taken", taken_count, 0);
    idle(2);

    // Randomized traffic with random consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] x;
      case ($urandom_range(0, 3))
        0: x = '0;
        1: x = W'(1) << (W - 1);
        default: x = W'($urandom);
      endcase
      send(8'($urandom), x);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cond_eval_pipe.md
Name: cond_eval_pipe

Overview:
Parametrised, pipelined successor to the 8-bit combinational condition evaluator.
- Evaluates a Turing-Complete-style condition code against a WIDTH-bit operand, with signed or unsigned interpretation.
- Results pass through a valid/ready handshake with a 2-entry output buffer.
- Sits between the ALU result path and the branch/jump-control logic, so that backpressure from the branch unit does not stall the ALU combinationally.

Parameters:
WIDTH, 8, operand width in bits (>=2)
CNT_WIDTH, 16, width of statistics counters (only used with COND_STATS_EN)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
in_valid  input  1  Condition/Input valid this cycle
in_ready  output  1  block can accept this cycle
Condition  input  8  [2:0] code, [3] unsigned mode, [7:4] ignored
Input  input  WIDTH  operand
out_valid  output  1  Result valid
out_ready  input  1  consumer accepts Result this cycle
Result  output  1  evaluated condition, head of buffer
stats_clr  input  1  synchronous clear of counters
eval_count  output  CNT_WIDTH  results popped
taken_count  output  CNT_WIDTH  results popped with Result=1

Behaviour:
- Evaluation (combinational at input; neg = Input[WIDTH-1] & ~Condition[3]; zero = (Input==0)):
  - code 0: 0
  - code 1: zero
  - code 2: neg
  - code 3: neg|zero
  - code 4: 1
  - code 5: ~zero
  - code 6: ~neg
  - code 7: ~neg & ~zero
- Unsigned mode (bit3=1): neg forced 0, so code 2 gives 0 and code 6 gives 1.
- Buffer: 2-entry FIFO of 1-bit results, occupancy register cnt in {0,1,2}.
  - in_ready = (cnt != 2). It derives only from registers, with no combinational path from out_ready.
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - out_valid = (cnt != 0). Result = head entry, 0 when cnt==0.
- Latency: a push in cycle N makes out_valid high in cycle N+1 if the buffer was empty. There is no bypass.
- Simultaneous push+pop:
  - cnt=1: cnt stays 1, the new entry goes behind the head, order preserved.
  - cnt=2: no push is possible, pop leaves cnt=1.
- in_valid while in_ready=0: the input is ignored. The producer must hold it.
- Result and out_valid are stable while out_valid=1 and out_ready=0.
- Reset (rst=0, any time, asynchronous):
  - cnt=0, out_valid=0, Result=0, in_ready=1, counters 0.
  - A result accepted in the reset cycle is discarded.
  - Release is synchronised by the user; no mid-flight state survives.

Optional Feature:
Macro COND_STATS_EN.
- Defined:
  - eval_count increments on every pop.
  - taken_count increments on pops with Result=1.
  - Both saturate at all-ones, with no wrap.
  - stats_clr=1 zeroes both next edge and has priority over a same-cycle increment.
- Undefined:
  - Counters are not instantiated.
  - eval_count and taken_count are tied to 0.
  - stats_clr is ignored.
  - Handshake and Result behaviour is identical.

Test Plan:
1. Reset, then WIDTH=8, push Condition=0x01, Input=0x00 with out_ready=1 -> out_valid=1 next cycle, Result=1; then Input=0x05 -> Result=0.
2. Signed vs unsigned, Input=0x80:
   - Condition=0x02 -> Result=1.
   - Condition=0x0A -> Result=0.
   - Condition=0x07 -> Result=0.
   - Condition=0x0F -> Result=1.
3. Backpressure, out_ready=0, push codes 4, 0, 4:
   - Accepted on cycles 0 and 1; in_ready=0 from cycle 2, so the third push is held.
   - Raise out_ready -> Results 1, 0, then 1, in order, with no loss or duplication.
4. Steady stream, in_valid=out_ready=1 for 20 cycles -> one accept per cycle, cnt stays 1, Results match evaluation per code sweep 0..7.
5. Assert rst=0 asynchronously mid-stream with cnt=2 -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge; no stale Result after release.
6. COND_STATS_EN with CNT_WIDTH=4:
   - 20 pops all taken -> eval_count=taken_count=15 (saturated).
   - stats_clr coincident with a pop -> both 0 next cycle.
   - Without the macro, both read 0 throughout.
